// File: rtl/ascii_num_stream_parser.sv
// Streaming ASCII-decimal to signed integer parser with valid/ready flow control.
// Optional build macro ASCII_NUM_SAT_EN: saturate out_data on overflow instead of wrapping.
module ascii_num_stream_parser #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf,
  output logic             out_err,
  output logic [CNT_W-1:0] num_count
);

  localparam int AW = WIDTH + 4;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SIGN   = 2'd1;
  localparam logic [1:0] DIGITS = 2'd2;
  localparam logic [1:0] SKIP   = 2'd3;

  logic [1:0]       state, st_c;
  logic [WIDTH-1:0] mag, mag_c;
  logic             neg, neg_c, ovf, ovf_c;
  logic             is_digit, is_minus, is_delim;
  logic             accept, flush_en, term, emit;
  logic [AW-1:0]    nxt, lim;
  logic signed [WIDTH-1:0] value;

  function automatic logic signed [WIDTH-1:0] wrap_value(input logic [WIDTH-1:0] m,
                                                         input logic n);
    return n ? -$signed(m) : $signed(m);
  endfunction

`ifdef ASCII_NUM_SAT_EN
  function automatic logic signed [WIDTH-1:0] sat_value(input logic signed [WIDTH-1:0] v,
                                                        input logic n, input logic o);
    if (!o) return v;
    return n ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction
`endif

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign flush_en = flush && in_ready;

  assign is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
  assign is_minus = (in_data == 8'h2D);
  assign is_delim = (in_data == 8'h20) || (in_data == 8'h2C) || (in_data == 8'h0D) ||
                    (in_data == 8'h0A) || (in_data == 8'h09);

  // mag is held at zero while idle, so the first digit accumulates from zero
  assign nxt = {4'b0, mag} * AW'(10) + AW'(in_data[3:0]);
  assign lim = neg ? (AW'(1) << (WIDTH-1)) : ((AW'(1) << (WIDTH-1)) - AW'(1));

  always_comb begin
    st_c  = state;
    mag_c = mag;
    neg_c = neg;
    ovf_c = ovf;
    if (accept && !is_delim) begin
      if (state == SKIP) begin
        st_c = SKIP;
      end else if (is_digit) begin
        st_c  = DIGITS;
        mag_c = nxt[WIDTH-1:0];
        if (nxt > lim) ovf_c = 1'b1;
      end else if (is_minus && state == IDLE) begin
        st_c  = SIGN;
        neg_c = 1'b1;
      end else begin
        st_c = SKIP;
      end
    end
    // a char sharing the cycle with flush is folded in first, then flush terminates
    term = (accept && is_delim) || flush_en;
    emit = term && (st_c != IDLE);
  end

`ifdef ASCII_NUM_SAT_EN
  assign value = sat_value(wrap_value(mag_c, neg_c), neg_c, ovf_c);
`else
  assign value = wrap_value(mag_c, neg_c);
`endif

  // output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mag       <= '0;
      neg       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_err   <= 1'b0;
      num_count <= '0;
    end else begin
      if (emit) begin
        state     <= IDLE;
        mag       <= '0;
        neg       <= 1'b0;
        ovf       <= 1'b0;
        out_valid <= 1'b1;
        out_err   <= (st_c != DIGITS);
        out_ovf   <= (st_c == DIGITS) && ovf_c;
        out_data  <= (st_c == DIGITS) ? value : '0;
      end else begin
        state <= st_c;
        mag   <= mag_c;
        neg   <= neg_c;
        ovf   <= ovf_c;
        if (out_ready) out_valid <= 1'b0;
      end
      if (out_valid && out_ready) num_count <= num_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ascii_num_stream_parser.sv
// Directed bench for ascii_num_stream_parser at WIDTH=16: vector table plus corner sequences.
module tb_ascii_num_stream_parser;

  localparam int W = 16;
  localparam int NV = 7;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         flush = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_ovf;
  logic         out_err;
  logic [15:0]  num_count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] v;
    logic         o;
    logic         e;
  } res_t;

  typedef struct {
    string              text;
    int                 n;
    logic [2:0][W-1:0]  v;
    logic [2:0]         o;
    logic [2:0]         e;
  } vec_t;

  res_t got_q[$];
  vec_t vecs[NV];

  ascii_num_stream_parser #(.WIDTH(W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ovf(out_ovf), .out_err(out_err), .num_count(num_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && out_valid && out_ready) got_q.push_back('{out_data, out_ovf, out_err});

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string t, input int n, input int v0, input int v1,
                              input int v2, input logic [2:0] o, input logic [2:0] e);
    vec_t r;
    r.text = t;
    r.n    = n;
    r.v[0] = W'(v0);
    r.v[1] = W'(v1);
    r.v[2] = W'(v2);
    r.o    = o;
    r.e    = e;
    return r;
  endfunction

  // handshake sampled at the falling edge so a stalled char is never resent twice
  task automatic send_char(input logic [7:0] c, input logic fl);
    int   tries = 0;
    logic acc;
    in_data  = c;
    in_valid = 1'b1;
    flush    = fl;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 100);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: char %0d not accepted within 100 cycles", c);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b0);
  endtask

  initial begin
    int cnt0;
    vecs[0] = mk("123,-45\n", 2, 123, -45, 0, 3'b000, 3'b000);
    vecs[1] = mk("32767 -32768 ", 2, 32767, -32768, 0, 3'b000, 3'b000);
`ifdef ASCII_NUM_SAT_EN
    vecs[2] = mk("40000 ", 1, 32767, 0, 0, 3'b001, 3'b000);
    vecs[3] = mk("-40000,", 1, -32768, 0, 0, 3'b001, 3'b000);
`else
    vecs[2] = mk("40000 ", 1, -25536, 0, 0, 3'b001, 3'b000);
    vecs[3] = mk("-40000,", 1, 25536, 0, 0, 3'b001, 3'b000);
`endif
    vecs[4] = mk("1a2 - 7 ", 3, 0, 0, 7, 3'b000, 3'b011);
    vecs[5] = mk("  ,,", 0, 0, 0, 0, 3'b000, 3'b000);
    vecs[6] = mk("-0 007\t", 2, 0, 7, 0, 3'b000, 3'b000);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_ovf, out_err}, 0);
    chk("rst_num_count", num_count, 0);
    chk("rst_in_ready", in_ready, 1);

    for (int k = 0; k < NV; k++) begin
      got_q.delete();
      cnt0 = num_count;
      for (int i = 0; i < vecs[k].text.len(); i++) begin
        chk($sformatf("v%0d_in_ready", k), in_ready, 1);
        send_char(vecs[k].text[i], 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("v%0d_count", k), got_q.size(), vecs[k].n);
      for (int j = 0; j < vecs[k].n && j < got_q.size(); j++) begin
        chk($sformatf("v%0d_data%0d", k, j), $signed(got_q[j].v), $signed(vecs[k].v[j]));
        chk($sformatf("v%0d_ovf%0d", k, j), got_q[j].o, vecs[k].o[j]);
        chk($sformatf("v%0d_err%0d", k, j), got_q[j].e, vecs[k].e[j]);
      end
      chk($sformatf("v%0d_num_count", k), num_count, (cnt0 + vecs[k].n) % 65536);
    end

    // backpressure: "5 " fills the output register, the rest stalls
    got_q.delete();
    out_ready = 1'b0;
    fork
      send_str("5 6 ");
      begin
        repeat (8) @(posedge clk);
        #1;
        chk("bp_valid", out_valid, 1);
        chk("bp_data_held", $signed(out_data), 5);
        chk("bp_in_ready", in_ready, 0);
        #1 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    chk("bp_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("bp_first", $signed(got_q[0].v), 5);
      chk("bp_second", $signed(got_q[1].v), 6);
    end

    // flush together with the last digit, flush alone in IDLE, flush alone in DIGITS
    got_q.delete();
    send_char("8", 1'b0);
    send_char("9", 1'b1);
    chk("flush_latency_valid", out_valid, 1);
    chk("flush_data", $signed(out_data), 89);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    send_char("4", 1'b0);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_count", got_q.size(), 2);
    if (got_q.size() == 2) chk("flush_alone_data", $signed(got_q[1].v), 4);

    // reset in the middle of a number
    got_q.delete();
    send_str("12");
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("mrst_num_count", num_count, 0);
    chk("mrst_out_valid", out_valid, 0);
    send_str("3 ");
    chk("mrst_latency_valid", out_valid, 1);
    chk("mrst_data", $signed(out_data), 3);
    repeat (3) @(posedge clk);
    #1;
    chk("mrst_count", got_q.size(), 1);
    chk("mrst_num_count_after", num_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
